// File: rtl/sha256_feeder.sv
// sha256_feeder
//
// Bridges a byte-counted, big-endian 32-bit message stream to a SHA-256 core
// that consumes one 512-bit block as 16 contiguous words. The feeder applies
// SHA-256 padding and the 64-bit bit-length trailer. It sequences the core
// (reset, block start, completion wait, digest read-out) and presents the
// 256-bit digest with a one-cycle valid pulse.
//
// Ports
//   clk, rst         rising-edge clock, synchronous active-high reset
//   in_valid/ready   message word handshake
//   in_data          message bytes, first byte in [31:24]
//   in_last          final word of the message
//   in_bytes         valid bytes in in_data (0..4; 0 only with in_last)
//   core_rst_n       core reset (active low), pulsed once per message
//   core_calcu_en    block start, high with the first word of each block
//   core_word        word stream into the core
//   core_calcu_rdy   core block-complete indication
//   core_read_en     digest read strobe (8 consecutive cycles)
//   core_word_out    digest word from the core, one cycle after each strobe
//   digest           {H0..H7}, H0 in [255:224]; holds until next update
//   digest_valid     one-cycle pulse when digest is updated
module sha256_feeder (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         core_rst_n,
    output logic         core_calcu_en,
    output logic [31:0]  core_word,
    input  logic         core_calcu_rdy,
    output logic         core_read_en,
    input  logic [31:0]  core_word_out,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [2:0] {CRST, FILL, PAD, SEND, WAIT, READ, DONE} state_t;

    state_t             state, state_nx;
    logic [15:0][31:0]  blk_buf;
    logic [15:0][31:0]  pad_blk;
    logic [15:0][31:0]  xtra_blk;
    logic [4:0]         idx;
    logic [3:0]         cnt;
    logic [31:0]        byte_cnt;
    logic               last_seen;
    logic               extra;
    logic               extra_80;
    logic [2:0]         last_bytes;
    logic [4:0]         last_idx;
    logic [4:0]         p_idx;
    logic [31:0]        tail_word;
    logic [63:0]        len_bits;
    logic [223:0]       dig_sr;
    logic               acc;

    assign in_ready      = (state == FILL) && !idx[4];
    assign acc           = in_ready && in_valid;
    assign core_rst_n    = (state != CRST);
    assign core_calcu_en = (state == SEND) && (cnt == 4'd0);
    assign core_word     = (state == SEND) ? blk_buf[cnt] : 32'h0;
    assign core_read_en  = (state == READ) && !cnt[3];
    assign digest_valid  = (state == DONE);

    assign len_bits = {29'b0, byte_cnt, 3'b0};

    // A full final word (4 bytes) pushes the 0x80 marker into the next word;
    // p_idx == 16 means the marker spills entirely into the extra block.
    assign p_idx = last_idx + (last_bytes[2] ? 5'd1 : 5'd0);

    // Final word with unused bytes cleared and the 0x80 marker inserted.
    always_comb begin
        tail_word = blk_buf[last_idx[3:0]];
        if (!last_bytes[2]) begin
            case (last_bytes[1:0])
                2'd0:    tail_word = 32'h8000_0000;
                2'd1:    tail_word = {tail_word[31:24], 24'h80_0000};
                2'd2:    tail_word = {tail_word[31:16], 16'h8000};
                default: tail_word = {tail_word[31:8], 8'h80};
            endcase
        end
    end

    always_comb begin
        pad_blk = '0;
        for (int j = 0; j < 16; j++) begin
            if (5'(j) < last_idx)       pad_blk[j] = blk_buf[j];
            else if (5'(j) == last_idx) pad_blk[j] = tail_word;
            else if (5'(j) == p_idx)    pad_blk[j] = 32'h8000_0000;
        end
        // Length only fits in this block when the marker leaves words 14/15 free.
        if (p_idx <= 5'd13) begin
            pad_blk[14] = len_bits[63:32];
            pad_blk[15] = len_bits[31:0];
        end
    end

    always_comb begin
        xtra_blk     = '0;
        xtra_blk[0]  = extra_80 ? 32'h8000_0000 : 32'h0;
        xtra_blk[14] = len_bits[63:32];
        xtra_blk[15] = len_bits[31:0];
    end

    always_comb begin
        state_nx = state;
        case (state)
            CRST: state_nx = FILL;
            FILL: begin
                if (acc) begin
                    if (in_last)           state_nx = PAD;
                    else if (idx == 5'd15) state_nx = SEND;
                end
            end
            PAD:  state_nx = SEND;
            SEND: if (cnt == 4'd15) state_nx = WAIT;
            WAIT: begin
                if (core_calcu_rdy) begin
                    if (!last_seen) state_nx = FILL;
                    else if (extra) state_nx = SEND;
                    else            state_nx = READ;
                end
            end
            READ: if (cnt == 4'd8) state_nx = DONE;
            DONE: state_nx = CRST;
            default: state_nx = CRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CRST;
            idx        <= '0;
            cnt        <= '0;
            byte_cnt   <= '0;
            last_seen  <= 1'b0;
            extra      <= 1'b0;
            extra_80   <= 1'b0;
            last_bytes <= '0;
            last_idx   <= '0;
            digest     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                CRST: begin
                    idx       <= '0;
                    cnt       <= '0;
                    byte_cnt  <= '0;
                    last_seen <= 1'b0;
                    extra     <= 1'b0;
                    extra_80  <= 1'b0;
                end
                FILL: begin
                    cnt <= '0;
                    if (acc) begin
                        idx      <= idx + 5'd1;
                        byte_cnt <= byte_cnt + {29'b0, in_bytes};
                        if (in_last) begin
                            last_seen  <= 1'b1;
                            last_bytes <= in_bytes;
                            last_idx   <= idx;
                        end
                    end
                end
                PAD: begin
                    extra    <= (p_idx >= 5'd14);
                    extra_80 <= (p_idx == 5'd16);
                end
                SEND: cnt <= cnt + 4'd1;
                WAIT: begin
                    cnt <= '0;
                    if (core_calcu_rdy) begin
                        if (!last_seen) idx   <= '0;
                        else if (extra) extra <= 1'b0;
                    end
                end
                READ: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd8) digest <= {dig_sr, core_word_out};
                end
                default: ;
            endcase
        end
    end

    // Block buffer and digest shift register carry no reset: every word is
    // written before it is sent or presented.
    always_ff @(posedge clk) begin
        if (acc)
            blk_buf[idx[3:0]] <= in_data;
        else if (state == PAD)
            blk_buf <= pad_blk;
        else if ((state == WAIT) && core_calcu_rdy && last_seen && extra)
            blk_buf <= xtra_blk;
        // Digest words arrive one cycle after each strobe (cnt 1..8).
        if ((state == READ) && (cnt != 4'd0))
            dig_sr <= {dig_sr[191:0], core_word_out};
    end

endmodule

// File: tb/tb_sha256_feeder.sv
// Testbench for sha256_feeder: behavioural SHA-256 core model on the core
// side, random message traffic on the input side, and a byte-queue
// reference of SHA-256 padding and hashing.
module tb_sha256_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         core_rst_n;
    logic         core_calcu_en;
    logic [31:0]  core_word;
    logic         core_calcu_rdy;
    logic         core_read_en;
    logic [31:0]  core_word_out;
    logic [255:0] digest;
    logic         digest_valid;

    always #5 clk = ~clk;

    sha256_feeder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_bytes(in_bytes),
        .core_rst_n(core_rst_n), .core_calcu_en(core_calcu_en),
        .core_word(core_word), .core_calcu_rdy(core_calcu_rdy),
        .core_read_en(core_read_en), .core_word_out(core_word_out),
        .digest(digest), .digest_valid(digest_valid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Reference: pad the byte string, split into blocks, hash.
    logic [511:0] exp_blocks [$];
    logic [255:0] exp_digest;

    task automatic build_ref(input logic [7:0] m[$]);
        logic [7:0]   p[$];
        logic [63:0]  bits;
        logic [511:0] b;
        logic [255:0] h;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        exp_blocks.delete();
        h = IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int k = 0; k < 64; k++) b[511 - 8*k -: 8] = p[bi*64 + k];
            exp_blocks.push_back(b);
            h = compress(h, b);
        end
        exp_digest = h;
    endtask

    // Core model: latches 16 words after calcu_en, computes after a random
    // latency, then returns H0..H7 one cycle after each read strobe.
    logic [255:0] core_h;
    logic [511:0] core_blk;
    bit           core_coll, core_busy;
    int           core_wcnt, core_encnt, core_lat, core_rptr;
    logic [511:0] got_blocks [$];

    always @(posedge clk) begin
        if (core_rst_n !== 1'b1) begin
            core_h = IV; core_coll = 0; core_busy = 0; core_wcnt = 0; core_rptr = 0;
            core_calcu_rdy <= 1'b1;
            core_word_out  <= '0;
        end else begin
            if (core_calcu_en && !core_coll) begin
                core_coll = 1; core_wcnt = 0; core_encnt = 0;
                core_calcu_rdy <= 1'b0;
            end
            if (core_coll) begin
                if (core_calcu_en) core_encnt++;
                core_blk[511 - 32*core_wcnt -: 32] = core_word;
                core_wcnt++;
                if (core_wcnt == 16) begin
                    core_coll = 0;
                    got_blocks.push_back(core_blk);
                    chk("en_pulses", 512'(core_encnt), 512'd1);
                    core_busy = 1;
                    core_lat = $urandom_range(20, 1);
                end
            end else if (core_busy) begin
                core_lat--;
                if (core_lat == 0) begin
                    core_h = compress(core_h, core_blk);
                    core_busy = 0;
                    core_calcu_rdy <= 1'b1;
                end
            end
            if (core_read_en) begin
                core_word_out <= core_h[255 - 32*core_rptr -: 32];
                core_rptr = (core_rptr + 1) % 8;
            end
        end
    end

    logic [255:0] got_dig [$];
    int           got_crst [$];
    int           crst_run = 0;

    always @(posedge clk) begin
        if (rst === 1'b1) crst_run = 0;
        else if (core_rst_n === 1'b0) crst_run++;
    end

    always @(negedge clk) begin
        if (digest_valid === 1'b1) begin
            got_dig.push_back(digest);
            got_crst.push_back(crst_run);
            crst_run = 0;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [2:0] nb, input logic last,
                             input int gapmax, inout bit ok);
        int g, tmo;
        if (!ok) return;
        g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
        repeat (g) begin
            @(negedge clk);
            in_valid = 1'b0; in_data = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last;
        tmo = 0;
        while (!in_ready && tmo < 3000) begin
            @(negedge clk);
            tmo++;
        end
        if (!in_ready) begin
            chk("in_ready_tmo", 512'd0, 512'd1);
            ok = 0;
            in_valid = 1'b0;
        end
    endtask

    task automatic run_msg(input string tag, input logic [7:0] m[$], input int gapmax,
                           input bit tail0, output logic [255:0] dig);
        bit          ok;
        int          n, nw, nb, tmo;
        logic [31:0] d;
        logic        lastf;
        ok = 1;
        dig = '0;
        got_blocks.delete();
        build_ref(m);
        n = m.size();
        if (n == 0) begin
            send_beat($urandom, 3'd0, 1'b1, gapmax, ok);
        end else begin
            nw = (n + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                nb = (w == nw - 1) ? n - 4*w : 4;
                d = $urandom;   // unused tail bytes carry garbage on purpose
                for (int k = 0; k < nb; k++) d[31 - 8*k -: 8] = m[4*w + k];
                lastf = (w == nw - 1) && !(tail0 && nb == 4);
                send_beat(d, 3'(nb), lastf, gapmax, ok);
            end
            if (tail0 && (n % 4 == 0)) send_beat($urandom, 3'd0, 1'b1, gapmax, ok);
        end
        if (ok) begin
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
        end
        tmo = 0;
        while (got_dig.size() == 0 && tmo < 4000) begin
            @(negedge clk);
            tmo++;
        end
        chk({tag, "_dig_seen"}, 512'(got_dig.size() != 0), 512'd1);
        if (got_dig.size() != 0) begin
            dig = got_dig.pop_front();
            chk({tag, "_dig"}, 512'(dig), 512'(exp_digest));
            chk({tag, "_crst"}, 512'(got_crst.pop_front()), 512'd1);
        end
        chk({tag, "_nblk"}, 512'(got_blocks.size()), 512'(exp_blocks.size()));
        for (int i = 0; i < got_blocks.size() && i < exp_blocks.size(); i++)
            chk($sformatf("%s_blk%0d", tag, i), got_blocks[i], exp_blocks[i]);
        // digest_valid must be a single-cycle pulse
        repeat (2) @(negedge clk);
        chk({tag, "_pulse"}, 512'(got_dig.size()), 512'd0);
        got_dig.delete();
        got_crst.delete();
    endtask

    logic [7:0]   msg [$];
    logic [255:0] dig;
    string        s56;
    int           lens [$];
    int           len, tmo;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 512'({in_ready, core_rst_n, core_calcu_en, core_read_en, digest_valid}), 512'd0);
        chk("rst_word", 512'(core_word), 512'd0);
        chk("rst_dig", 512'(digest), 512'd0);
        rst = 1'b0;
        #1;
        chk("crst_rstn", 512'(core_rst_n), 512'd0);
        @(negedge clk);
        chk("fill_rstn", 512'(core_rst_n), 512'd1);
        chk("fill_ready", 512'(in_ready), 512'd1);

        msg.delete();
        run_msg("empty", msg, 0, 1'b0, dig);
        chk("empty_known", 512'(dig),
            512'(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855));

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc", msg, 0, 1'b0, dig);
        chk("abc_known", 512'(dig),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        if (got_blocks.size() > 0) begin
            chk("abc_w0", 512'(got_blocks[0][511:480]), 512'h61626380);
            chk("abc_w15", 512'(got_blocks[0][31:0]), 512'h18);
        end

        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg.delete();
        for (int i = 0; i < s56.len(); i++) msg.push_back(s56[i]);
        run_msg("b56", msg, 0, 1'b0, dig);
        chk("b56_known", 512'(dig),
            512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));
        if (got_blocks.size() > 1) chk("b56_blk1", got_blocks[1], 512'h1c0);

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("abc_gap", msg, 6, 1'b0, dig);
        chk("abc_gap_known", 512'(dig),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));

        // Reset in the middle of SEND, then resend.
        begin
            bit ok;
            ok = 1;
            got_blocks.delete();
            send_beat(32'h616263a5, 3'd3, 1'b1, 0, ok);
            @(negedge clk);
            in_valid = 1'b0; in_last = 1'b0;
            tmo = 0;
            while (core_calcu_en !== 1'b1 && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            chk("mid_send_seen", 512'(core_calcu_en), 512'd1);
            repeat (4) @(negedge clk);
            rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("mid_rst_ctl",
                    512'({in_ready, core_rst_n, core_calcu_en, core_read_en, digest_valid}), 512'd0);
                chk("mid_rst_word", 512'(core_word), 512'd0);
                chk("mid_rst_dig", 512'(digest), 512'd0);
            end
            rst = 1'b0;
            #1;
            chk("mid_crst_rstn", 512'(core_rst_n), 512'd0);
            @(negedge clk);
            chk("mid_fill_rstn", 512'(core_rst_n), 512'd1);
            chk("mid_noblk", 512'(got_blocks.size()), 512'd0);
            chk("mid_nodig", 512'(got_dig.size()), 512'd0);
            msg = '{8'h61, 8'h62, 8'h63};
            run_msg("abc_after_rst", msg, 0, 1'b0, dig);
            chk("abc_after_rst_known", 512'(dig),
                512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        end

        msg = '{8'h61, 8'h62, 8'h63};
        run_msg("b2b_abc", msg, 0, 1'b0, dig);
        chk("b2b_abc_known", 512'(dig),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        msg.delete();
        run_msg("b2b_empty", msg, 0, 1'b0, dig);
        chk("b2b_empty_known", 512'(dig),
            512'(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855));

        // Random messages around the padding boundaries plus random lengths.
        lens = '{1, 3, 4, 52, 55, 56, 57, 59, 60, 61, 63, 64, 65, 119, 120, 128};
        for (int i = 0; i < lens.size() + 4; i++) begin
            len = (i < lens.size()) ? lens[i] : $urandom_range(200, 0);
            msg.delete();
            for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
            run_msg($sformatf("rnd%0d_len%0d", i, len), msg, $urandom_range(3, 0),
                    1'($urandom_range(1, 0)), dig);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
